// File: rtl/mem_port_arbiter.sv
// Arbiter for the core's single memory port: data accesses win, fetch is protected
// from starvation, one transaction in flight, responses routed to the owning requester.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic        own_data_q, own_data_d;
    logic [3:0]  streak_q, streak_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        if_ready_q, if_ready_d;
    logic        d_ready_q, d_ready_d;
    logic        if_done_q, if_done_d;
    logic        d_done_q, d_done_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        grant_data;
    logic        grant_fetch;

    // Fetch only beats data under contention once the data streak hits the limit.
    always_comb begin
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        if (state_q == IDLE) begin
            if (d_req && if_req) begin
                if (streak_q == LIMIT) grant_fetch = 1'b1;
                else                   grant_data  = 1'b1;
            end else if (d_req) begin
                grant_data = 1'b1;
            end else if (if_req) begin
                grant_fetch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_data || grant_fetch) state_d = ISSUE;
            ISSUE:   if (mem_ack) state_d = mem_we_q ? RESP : WAIT_RD;
            WAIT_RD: if (mem_rvalid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        own_data_d  = own_data_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    own_data_d  = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_we ? d_wdata : 32'd0;
                    mem_wstrb_d = d_we ? d_wstrb : 4'b0000;
                    d_ready_d   = 1'b1;
                    if (!if_req)               streak_d = 4'd0;
                    else if (streak_q != LIMIT) streak_d = streak_q + 4'd1;
                end else if (grant_fetch) begin
                    own_data_d  = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = 32'd0;
                    mem_wstrb_d = 4'b0000;
                    if_ready_d  = 1'b1;
                    streak_d    = 4'd0;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    // Writes complete on acceptance; reads wait for returned data.
                    if (mem_we_q) begin
                        d_done_d  = own_data_q;
                        if_done_d = !own_data_q;
                    end
                end
            end
            WAIT_RD: begin
                if (mem_rvalid) begin
                    if (own_data_q) begin
                        d_rdata_d = mem_rdata;
                        d_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            own_data_q  <= 1'b0;
            streak_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'b0000;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            own_data_q  <= own_data_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_ready  = if_ready_q;
    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch and the load/store path of the three-stage core.
- Serialises accesses with one outstanding transaction at a time.
- Gives data accesses priority, with a starvation guard that guarantees fetch progress.
- Returns read data and write completion to the requester that owns the transaction; the load-extraction logic downstream consumes the raw 32-bit word.

Parameters:
- STARVE_LIMIT, 4: number of consecutive data grants made while fetch was waiting; after that count, fetch wins the next contention. Legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ready.
- if_addr  in  32  fetch word address.
- if_ready  out  1  one-cycle pulse: fetch request latched.
- if_done  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  32  fetched word.
- d_req  in  1  data request; held with all d_* fields stable until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data, already lane-aligned.
- d_wstrb  in  4  byte enables for stores.
- d_ready  out  1  one-cycle pulse: data request latched.
- d_done  out  1  one-cycle pulse: load data valid, or store complete.
- d_rdata  out  32  raw loaded word.
- mem_req  out  1  request to memory; held until mem_ack.
- mem_we  out  1  write enable.
- mem_addr  out  32  address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  byte strobes; 4'b0000 on reads.
- mem_ack  in  1  memory accepted the request this cycle (valid only while mem_req=1).
- mem_rvalid  in  1  read data returned; earliest one cycle after mem_ack.
- mem_rdata  in  32  read data.

Behaviour:
- All outputs are registered. On reset (synchronous, active-high), every output goes to 0, the state machine goes to IDLE and the streak counter goes to 0.
- State machine states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE arbitration:
  - Only data requesting: grant data.
  - Only fetch requesting: grant fetch.
  - Both requesting: grant data unless streak == STARVE_LIMIT, in which case grant fetch.
  - On any grant: latch the owner and the request fields, pulse the owner's *_ready on the next edge, and go to ISSUE.
- Streak counter:
  - Increments on a data grant made while if_req=1.
  - Clears to 0 on a fetch grant, or on a data grant made while if_req=0.
  - Saturates at STARVE_LIMIT.
- ISSUE:
  - mem_req=1 with the latched fields.
  - On mem_ack with a read: go to WAIT_RD.
  - On mem_ack with a write: go to RESP.
- WAIT_RD: on mem_rvalid, latch mem_rdata into the owner's *_rdata register and go to RESP. mem_rvalid arriving in the same cycle as mem_ack is not legal and is ignored.
- RESP: pulse the owner's *_done for exactly one cycle, then go to IDLE. No arbitration happens in RESP.
- Minimum latency, with a request seen in IDLE at cycle t:
  - *_ready at t+1.
  - mem_req first high at t+1.
  - Write with mem_ack at t+1: d_done at t+2.
  - Read with mem_ack at t+1 and mem_rvalid at t+2: *_done at t+3, with rdata valid that cycle.
- Back-to-back: each access occupies at least 3 cycles (write) or 4 cycles (read) from IDLE to IDLE.
- Requests are ignored outside IDLE. A requester dropping *_req before *_ready is legal; no grant is made for it.
- *_rdata holds its value until the next read completes for that requester. d_rdata is not updated by stores.
- mem_ack outside ISSUE, and mem_rvalid outside WAIT_RD, are ignored with no state change.
- mem_req never drops before mem_ack. mem_wdata and mem_wstrb are don't-care on reads but driven with mem_wstrb = 0.
- Reset mid-transaction: the next edge returns to IDLE with mem_req=0 and no *_done is issued. A late mem_rvalid arriving afterwards is ignored.

Test Plan:
- Single load: d_req, d_we=0, d_addr=0x100; memory acks at t+1 and returns 0xDEADBEEF at t+2 -> d_ready at t+1, d_done at t+3, d_rdata=0xDEADBEEF, if_done never asserts.
- Store: d_we=1, d_addr=0x104, d_wdata=0x0000AB00, d_wstrb=4'b0010 -> mem_we=1 and mem_wstrb=4'b0010 while mem_req=1; d_done one cycle after mem_ack; d_rdata unchanged.
- Contention with STARVE_LIMIT=4: if_req and d_req held high continuously -> grant order D,D,D,D,I,D,D,D,D,I; streak resets after each fetch grant.
- Slow memory: mem_ack delayed 3 cycles, then mem_rvalid delayed 5 cycles after ack -> mem_req and mem_addr stay stable until ack; exactly one *_done; no second grant before RESP completes.
- Spurious strobes: mem_rvalid pulsed in IDLE and mem_ack pulsed in WAIT_RD -> no state change and no *_done.
- Reset while in WAIT_RD, followed by a mem_rvalid 2 cycles later -> all outputs 0 after the reset edge, no d_done or if_done, and a fresh fetch to 0x0 then completes normally.
